// File: rtl/mtimer_sched.sv
// mtimer_sched: shares the single machine-timer compare register between
// NUM_CH software timer channels. Each channel holds a 64-bit deadline;
// the scheduler scans for the earliest enabled deadline and programs the
// timer's mtimecmp with the glitch-free lo(max)/hi/lo write sequence. It
// raises a per-channel pending flag once time_in reaches that deadline.
//
// Optional build macro MTIMER_SCHED_PERIODIC_EN adds a 32-bit period
// register (reg 3) and a PERIODIC ctrl bit (bit2) for auto-rearming
// channels. Without it reg 3 and ctrl bit2 read 0 and ignore writes.
//
// Timer write handshake: mt_wr_en is a request that stays asserted with
// mt_addr/mt_wr_data held stable until a cycle in which mt_gnt is high;
// that cycle completes the transfer. mt_gnt is ignored while mt_wr_en is 0.
//
// The scheduler FSM state is visible as the enum signal state_q.

module mtimer_sched #(
  parameter int NUM_CH = 4,
  parameter int CH_AW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_rd_en,
  input  logic              cfg_wr_en,
  input  logic [CH_AW+1:0]  cfg_addr,
  input  logic [31:0]       cfg_wr_data,
  input  logic [3:0]        cfg_wr_strobe,
  output logic [31:0]       cfg_rd_data,
  input  logic [63:0]       time_in,
  output logic              mt_wr_en,
  output logic [1:0]        mt_addr,
  output logic [31:0]       mt_wr_data,
  output logic [3:0]        mt_wr_strobe,
  input  logic              mt_gnt,
  output logic [NUM_CH-1:0] irq_pending,
  output logic              irq
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SCAN      = 3'd1,
    S_WR_LO_MAX = 3'd2,
    S_WR_HI     = 3'd3,
    S_WR_LO     = 3'd4
  } state_t;

  // Channel state
  logic [63:0]       cmp_q [NUM_CH];
  logic [63:0]       cmp_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] fire;
`ifdef MTIMER_SCHED_PERIODIC_EN
  logic [31:0]       period_q [NUM_CH];
  logic [31:0]       period_d [NUM_CH];
  logic [NUM_CH-1:0] per_q, per_d;
`endif

  // Host address decode
  logic [CH_AW-1:0] sel_ch;
  logic [1:0]       sel_reg;
  logic             sel_valid;
  logic             dirty_set;

  // Scheduler state
  state_t           state_q;
  logic             dirty_q;
  logic [63:0]      best_q;
  logic [63:0]      best_cand;
  logic [63:0]      last_prog_q;
  logic [CH_AW-1:0] idx_q;

  assign sel_ch       = cfg_addr[CH_AW+1:2];
  assign sel_reg      = cfg_addr[1:0];
  assign sel_valid    = ({{(32-CH_AW){1'b0}}, sel_ch} < 32'(NUM_CH));
  assign mt_wr_strobe = 4'hF;
  assign irq_pending  = pend_q;

  // Merge the byte lanes selected by st from wd over old
  function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  st);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = st[b] ? wd[b*8 +: 8] : old[b*8 +: 8];
    end
    return res;
  endfunction

  // Deadline reached: enabled channel whose compare value is <= current time
  always_comb begin
    fire = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fire[i] = en_q[i] && (time_in >= cmp_q[i]);
    end
  end

  // Channel next state: fire applies first, a host write then overrides the
  // field it touches, except that a fire-driven PEND set beats W1C
  always_comb begin
    dirty_set = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cmp_d[i]  = cmp_q[i];
      en_d[i]   = en_q[i];
      pend_d[i] = pend_q[i];
`ifdef MTIMER_SCHED_PERIODIC_EN
      period_d[i] = period_q[i];
      per_d[i]    = per_q[i];
`endif
      if (fire[i]) begin
        pend_d[i] = 1'b1;
        dirty_set = 1'b1;
`ifdef MTIMER_SCHED_PERIODIC_EN
        if (per_q[i] && (period_q[i] != 32'd0)) begin
          cmp_d[i] = cmp_q[i] + {32'd0, period_q[i]};
        end else begin
          en_d[i] = 1'b0;
        end
`else
        en_d[i] = 1'b0;
`endif
      end
      if (cfg_wr_en && sel_valid && (sel_ch == CH_AW'(i))) begin
        case (sel_reg)
          2'd0: begin
            cmp_d[i][31:0] = apply_strb(cmp_d[i][31:0], cfg_wr_data, cfg_wr_strobe);
            dirty_set      = 1'b1;
          end
          2'd1: begin
            cmp_d[i][63:32] = apply_strb(cmp_d[i][63:32], cfg_wr_data, cfg_wr_strobe);
            dirty_set       = 1'b1;
          end
          2'd2: begin
            dirty_set = 1'b1;
            if (cfg_wr_strobe[0]) begin
              en_d[i] = cfg_wr_data[0];
              if (cfg_wr_data[1] && !fire[i]) begin
                pend_d[i] = 1'b0;
              end
`ifdef MTIMER_SCHED_PERIODIC_EN
              per_d[i] = cfg_wr_data[2];
`endif
            end
          end
          default: begin
`ifdef MTIMER_SCHED_PERIODIC_EN
            period_d[i] = apply_strb(period_q[i], cfg_wr_data, cfg_wr_strobe);
`endif
          end
        endcase
      end
    end
  end

  // Channel registers and the registered interrupt summary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cmp_q[i] <= '0;
      end
      en_q   <= '0;
      pend_q <= '0;
      irq    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cmp_q[i] <= cmp_d[i];
      end
      en_q   <= en_d;
      pend_q <= pend_d;
      irq    <= |pend_d;
    end
  end

`ifdef MTIMER_SCHED_PERIODIC_EN
  // Period and PERIODIC bit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= '0;
      end
      per_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= period_d[i];
      end
      per_q <= per_d;
    end
  end
`endif

  // Combinational host read mux; zero when not reading
  always_comb begin
    cfg_rd_data = '0;
    if (cfg_rd_en && sel_valid) begin
      case (sel_reg)
        2'd0: cfg_rd_data = cmp_q[sel_ch][31:0];
        2'd1: cfg_rd_data = cmp_q[sel_ch][63:32];
`ifdef MTIMER_SCHED_PERIODIC_EN
        2'd2: cfg_rd_data = {29'd0, per_q[sel_ch], pend_q[sel_ch], en_q[sel_ch]};
        default: cfg_rd_data = period_q[sel_ch];
`else
        2'd2: cfg_rd_data = {30'd0, pend_q[sel_ch], en_q[sel_ch]};
        default: cfg_rd_data = '0;
`endif
      endcase
    end
  end

  // Running minimum for the channel under scan; strict < keeps the lowest index on ties
  always_comb begin
    best_cand = best_q;
    if (en_q[idx_q] && (cmp_q[idx_q] < best_q)) begin
      best_cand = cmp_q[idx_q];
    end
  end

  // Scheduler FSM: scan for the earliest deadline, then lo(max)/hi/lo writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dirty_q     <= 1'b1;
      best_q      <= '1;
      idx_q       <= '0;
      last_prog_q <= '0;
      mt_wr_en    <= 1'b0;
      mt_addr     <= 2'b00;
      mt_wr_data  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dirty_q) begin
            dirty_q <= 1'b0;
            best_q  <= '1;
            idx_q   <= '0;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          best_q <= best_cand;
          if (idx_q == CH_AW'(NUM_CH - 1)) begin
            if (best_cand == last_prog_q) begin
              state_q <= S_IDLE;
            end else begin
              state_q    <= S_WR_LO_MAX;
              mt_wr_en   <= 1'b1;
              mt_addr    <= 2'b10;
              mt_wr_data <= 32'hFFFF_FFFF;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_WR_LO_MAX: begin
          if (mt_gnt) begin
            state_q    <= S_WR_HI;
            mt_addr    <= 2'b11;
            mt_wr_data <= best_q[63:32];
          end
        end
        S_WR_HI: begin
          if (mt_gnt) begin
            state_q    <= S_WR_LO;
            mt_addr    <= 2'b10;
            mt_wr_data <= best_q[31:0];
          end
        end
        S_WR_LO: begin
          if (mt_gnt) begin
            state_q     <= S_IDLE;
            mt_wr_en    <= 1'b0;
            last_prog_q <= best_q;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          mt_wr_en <= 1'b0;
        end
      endcase
      // A new fire or host write always forces another scan
      if (dirty_set) begin
        dirty_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mtimer_sched.sv
// Bench for mtimer_sched: register-map vectors from a table, plus
// hand-written sequences for timer programming, fires, grant stalls and
// rewrites during an active programming sequence. Timer writes are checked
// against an expected queue filled when the stimulus is driven.

module tb_mtimer_sched;

  localparam int NUM_CH = 4;
  localparam int CH_AW  = 2;

`ifdef MTIMER_SCHED_PERIODIC_EN
  localparam logic [31:0] PERIOD_RB = 32'd50;
`else
  localparam logic [31:0] PERIOD_RB = 32'd0;
`endif

  logic              clk;
  logic              rst_n;
  logic              cfg_rd_en;
  logic              cfg_wr_en;
  logic [CH_AW+1:0]  cfg_addr;
  logic [31:0]       cfg_wr_data;
  logic [3:0]        cfg_wr_strobe;
  logic [31:0]       cfg_rd_data;
  logic [63:0]       time_in;
  logic              mt_wr_en;
  logic [1:0]        mt_addr;
  logic [31:0]       mt_wr_data;
  logic [3:0]        mt_wr_strobe;
  logic              mt_gnt;
  logic [NUM_CH-1:0] irq_pending;
  logic              irq;

  mtimer_sched #(.NUM_CH(NUM_CH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_rd_en    (cfg_rd_en),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_addr     (cfg_addr),
    .cfg_wr_data  (cfg_wr_data),
    .cfg_wr_strobe(cfg_wr_strobe),
    .cfg_rd_data  (cfg_rd_data),
    .time_in      (time_in),
    .mt_wr_en     (mt_wr_en),
    .mt_addr      (mt_addr),
    .mt_wr_data   (mt_wr_data),
    .mt_wr_strobe (mt_wr_strobe),
    .mt_gnt       (mt_gnt),
    .irq_pending  (irq_pending),
    .irq          (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks    = 0;
  int failures  = 0;
  int grant_cnt = 0;
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_seq(input logic [63:0] v);
    exp_q.push_back({2'b10, 32'hFFFF_FFFF});
    exp_q.push_back({2'b11, v[63:32]});
    exp_q.push_back({2'b10, v[31:0]});
  endtask

  // Timer-port monitor: each granted write pops one expectation; a held
  // request must keep address and data stable
  logic [33:0] hold_val;
  logic        hold_vld = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        check("mt_hold", {mt_wr_en, mt_addr, mt_wr_data}, {1'b1, hold_val});
      end
      hold_vld = mt_wr_en && !mt_gnt;
      hold_val = {mt_addr, mt_wr_data};
      if (mt_wr_en && mt_gnt) begin
        grant_cnt++;
        check("mt_strobe", mt_wr_strobe, 4'hF);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mt_unexpected: got %h expected no write", {mt_addr, mt_wr_data});
        end else begin
          check("mt_write", {mt_addr, mt_wr_data}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic host_wr(input int ch, input logic [1:0] rg, input logic [31:0] d,
                         input logic [3:0] st);
    @(negedge clk);
    cfg_wr_en     = 1'b1;
    cfg_addr      = {ch[CH_AW-1:0], rg};
    cfg_wr_data   = d;
    cfg_wr_strobe = st;
    @(negedge clk);
    cfg_wr_en     = 1'b0;
    cfg_wr_strobe = 4'h0;
  endtask

  task automatic host_rd(input int ch, input logic [1:0] rg, output logic [31:0] d);
    @(negedge clk);
    cfg_rd_en = 1'b1;
    cfg_addr  = {ch[CH_AW-1:0], rg};
    #1;
    d = cfg_rd_data;
    cfg_rd_en = 1'b0;
  endtask

  // Wait for all expected timer writes, then give a quiet window in which
  // any extra write is reported by the monitor
  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mt_wr_en) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3 * NUM_CH + 6) @(negedge clk);
  endtask

  // ---------------- register-map vectors ----------------
  typedef struct {
    bit          do_wr;
    int          ch;
    logic [1:0]  rg;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] rd;
    int          g0;
    bit          found;

    vecs[0] = '{1'b1, 0, 2'd0, 32'h1234_5678, 4'hF, 32'h1234_5678};
    vecs[1] = '{1'b1, 0, 2'd0, 32'hAAAA_AAAA, 4'h2, 32'h1234_AA78};
    vecs[2] = '{1'b1, 0, 2'd1, 32'hCAFE_0001, 4'hF, 32'hCAFE_0001};
    vecs[3] = '{1'b1, 3, 2'd1, 32'hDEAD_BEEF, 4'hC, 32'hDEAD_0000};
    vecs[4] = '{1'b0, 1, 2'd2, 32'h0,         4'h0, 32'h0};
    vecs[5] = '{1'b1, 2, 2'd2, 32'hFFFF_FFF8, 4'hF, 32'h0};
    vecs[6] = '{1'b1, 3, 2'd3, 32'd50,        4'hF, PERIOD_RB};
    vecs[7] = '{1'b0, 1, 2'd1, 32'h0,         4'h0, 32'h0};

    rst_n = 1'b0; cfg_rd_en = 1'b0; cfg_wr_en = 1'b0; cfg_addr = '0;
    cfg_wr_data = '0; cfg_wr_strobe = '0; time_in = '0; mt_gnt = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mt_wr_en", mt_wr_en, 0);
    check("rst_mt_addr", mt_addr, 0);
    check("rst_mt_data", mt_wr_data, 0);
    check("rst_irq", irq, 0);
    check("rst_irq_pending", irq_pending, 0);

    // Post-reset all-ones programming, starting NUM_CH+1 cycles after release
    push_seq(64'hFFFF_FFFF_FFFF_FFFF);
    rst_n = 1'b1;
    repeat (NUM_CH) @(negedge clk);
    check("boot_not_yet", mt_wr_en, 0);
    @(negedge clk);
    check("boot_first_req", {mt_wr_en, mt_addr}, {1'b1, 2'b10});
    wait_drain("boot");
    check("boot_idle_en", mt_wr_en, 0);
    check("boot_irq", irq, 0);

    // Register map table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_wr) host_wr(vecs[i].ch, vecs[i].rg, vecs[i].wdata, vecs[i].strb);
      host_rd(vecs[i].ch, vecs[i].rg, rd);
      check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end
    @(negedge clk);
    cfg_addr = {2'd0, 2'd0};
    #1;
    check("rd_idle_zero", cfg_rd_data, 0);
    wait_drain("regmap");

    // ch1 single deadline, exact-match fire, reprogram to all-ones
    host_wr(1, 2'd0, 32'h0000_0010, 4'hF);
    host_wr(1, 2'd1, 32'h0000_0001, 4'hF);
    push_seq(64'h0000_0001_0000_0010);
    host_wr(1, 2'd2, 32'h1, 4'hF);
    wait_drain("ch1_prog");
    host_rd(1, 2'd2, rd);
    check("ch1_ctrl_en", rd, 32'h1);
    @(negedge clk);
    time_in = 64'h0000_0001_0000_0010;
    push_seq(64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check("ch1_pending", irq_pending, 4'b0010);
    check("ch1_irq", irq, 1);
    host_rd(1, 2'd2, rd);
    check("ch1_ctrl_fired", rd, 32'h2);
    wait_drain("ch1_fire");
    host_wr(1, 2'd2, 32'h2, 4'hF);
    check("ch1_w1c", irq_pending, 4'b0000);
    time_in = 64'd0;

    // ch0=500, ch2=300: earliest wins, rescan after ch2 fires
    host_wr(0, 2'd0, 32'd500, 4'hF);
    host_wr(0, 2'd1, 32'd0, 4'hF);
    host_wr(2, 2'd0, 32'd300, 4'hF);
    host_wr(2, 2'd1, 32'd0, 4'hF);
    push_seq(64'd300);
    host_wr(2, 2'd2, 32'h1, 4'hF);
    host_wr(0, 2'd2, 32'h1, 4'hF);
    wait_drain("two_ch_prog");
    @(negedge clk);
    time_in = 64'd299;
    @(negedge clk);
    check("ch2_below", irq_pending, 4'b0000);
    time_in = 64'd300;
    push_seq(64'd500);
    @(negedge clk);
    check("ch2_pending", irq_pending, 4'b0100);
    wait_drain("ch2_fire");
    host_wr(2, 2'd2, 32'h2, 4'hF);
    time_in = 64'd500;
    push_seq(64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check("ch0_pending", irq_pending, 4'b0001);
    check("ch0_irq", irq, 1);
    wait_drain("ch0_fire");
    host_wr(0, 2'd2, 32'h2, 4'hF);
    check("ch0_irq_clear", irq, 0);
    time_in = 64'd0;

    // Grant stall in WR_HI for 5 cycles
    g0 = grant_cnt;
    host_wr(1, 2'd0, 32'h0000_0100, 4'hF);
    host_wr(1, 2'd1, 32'h0000_0002, 4'hF);
    push_seq(64'h0000_0002_0000_0100);
    host_wr(1, 2'd2, 32'h1, 4'hF);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(posedge clk);
      #2;
      if (mt_wr_en && mt_addr == 2'b11) found = 1'b1;
    end
    check("stall_reach_hi", found, 1);
    if (found) begin
      mt_gnt = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("stall_hi", {mt_wr_en, mt_addr, mt_wr_data}, {1'b1, 2'b11, 32'h0000_0002});
      end
      @(posedge clk);
      #2;
      mt_gnt = 1'b1;
    end
    wait_drain("stall");
    check("stall_grants", grant_cnt - g0, 3);
    push_seq(64'hFFFF_FFFF_FFFF_FFFF);
    host_wr(1, 2'd2, 32'h0, 4'hF);
    wait_drain("stall_off");

    // Rewrite ch0 while WR_LO_MAX is held: old value first, then new value
    host_wr(0, 2'd0, 32'h0000_0800, 4'hF);
    @(posedge clk);
    #2;
    mt_gnt = 1'b0;
    push_seq(64'h0000_0000_0000_0800);
    host_wr(0, 2'd2, 32'h1, 4'hF);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (mt_wr_en) found = 1'b1;
    end
    check("rw_lo_max", {found, mt_addr, mt_wr_data}, {1'b1, 2'b10, 32'hFFFF_FFFF});
    host_wr(0, 2'd0, 32'h0000_0900, 4'hF);
    push_seq(64'h0000_0000_0000_0900);
    @(posedge clk);
    #2;
    mt_gnt = 1'b1;
    wait_drain("rewrite");
    host_rd(0, 2'd0, rd);
    check("rw_cmp_lo", rd, 32'h0000_0900);
    push_seq(64'hFFFF_FFFF_FFFF_FFFF);
    host_wr(0, 2'd2, 32'h0, 4'hF);
    wait_drain("rewrite_off");

`ifdef MTIMER_SCHED_PERIODIC_EN
    // Periodic ch3: fire at 100 re-arms at 150
    host_wr(3, 2'd0, 32'd100, 4'hF);
    host_wr(3, 2'd1, 32'd0, 4'hF);
    host_wr(3, 2'd3, 32'd50, 4'hF);
    push_seq(64'd100);
    host_wr(3, 2'd2, 32'h5, 4'hF);
    wait_drain("per_prog");
    @(negedge clk);
    time_in = 64'd100;
    push_seq(64'd150);
    @(negedge clk);
    check("per_pending", irq_pending, 4'b1000);
    host_rd(3, 2'd0, rd);
    check("per_cmp", rd, 32'd150);
    host_rd(3, 2'd2, rd);
    check("per_ctrl", rd, 32'h7);
    wait_drain("per_fire");
    push_seq(64'hFFFF_FFFF_FFFF_FFFF);
    host_wr(3, 2'd2, 32'h2, 4'hF);
    wait_drain("per_off");
    time_in = 64'd0;
`endif

    check("final_irq", irq, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Run-time bound
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mtimer_sched.md
Name: mtimer_sched

Overview:
- Multi-channel one-shot/deadline scheduler that shares the single machine-timer compare register among NUM_CH software-visible timer channels.
- Holds one 64-bit deadline per channel and scans for the earliest enabled deadline.
- Programs the timer's mtimecmp through its DBus-style write port using the glitch-free lo/hi/lo sequence.
- Sits beside the timer as the sole writer of mtimecmp (timer addresses 2 and 3). It raises per-channel pending flags when deadlines pass.

Parameters:
- NUM_CH, 4, number of timer channels (1..16).
- CH_AW, $clog2(NUM_CH) (minimum 1), channel index width (derived; do not override).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- cfg_rd_en  input  1  host read enable.
- cfg_wr_en  input  1  host write enable.
- cfg_addr  input  CH_AW+2  {channel, reg[1:0]}.
- cfg_wr_data  input  32  host write data.
- cfg_wr_strobe  input  4  byte enables for host writes.
- cfg_rd_data  output  32  host read data.
- time_in  input  64  current mtime value (the timer's time read port).
- mt_wr_en  output  1  write request to the timer.
- mt_addr  output  2  timer register address; always 2'b10 or 2'b11.
- mt_wr_data  output  32  timer write data.
- mt_wr_strobe  output  4  always 4'hF.
- mt_gnt  input  1  write accepted this cycle.
- irq_pending  output  NUM_CH  per-channel pending flags.
- irq  output  1  OR of irq_pending.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n). All state clears asynchronously.
  - All outputs reset to 0. cmp registers reset to 64'h0, ctrl to 0, pending to 0.
  - The dirty flag resets to 1, so all-ones is programmed to the timer immediately after reset.
- Register map per channel (reg):
  - 0 = cmp[31:0].
  - 1 = cmp[63:32].
  - 2 = ctrl: bit0 EN (RW), bit1 PEND (read; write-1-clears), others read 0.
  - 3 = period (see Optional Feature).
- Host writes: byte-strobed. Any write to regs 0-2 sets dirty.
- Host reads: cfg_rd_data is combinational when cfg_rd_en, else 0.
- Fire check, every cycle, per channel: if EN and time_in >= cmp (unsigned 64-bit), then next cycle PEND<=1, EN<=0, dirty<=1.
  - Same cycle as a host write to that channel: the fire takes effect first, then the host write overrides the field it writes.
  - Exception: PEND set beats W1C.
- irq is registered: irq = |PEND.
- FSM states: IDLE, SCAN, WR_LO_MAX, WR_HI, WR_LO.
  - IDLE: if dirty, clear dirty, set best=64'hFFFF_FFFF_FFFF_FFFF, idx=0, go to SCAN.
  - SCAN: one channel per cycle. If EN and cmp < best, then best<=cmp. Ties: lowest index wins (strict <). After channel NUM_CH-1: if best == last_prog, go to IDLE; else go to WR_LO_MAX. SCAN takes exactly NUM_CH cycles.
  - WR_LO_MAX: mt_wr_en=1, mt_addr=2, data=32'hFFFF_FFFF. Hold until mt_gnt; on grant go to WR_HI.
  - WR_HI: addr=3, data=best[63:32]. On grant go to WR_LO.
  - WR_LO: addr=2, data=best[31:0]. On grant, last_prog<=best, go to IDLE.
  - mt_wr_data/mt_addr are stable while mt_wr_en=1 and mt_gnt=0.
- last_prog resets to 0, which guarantees the first program after reset.
- No enabled channel: best stays all-ones, so mtimecmp is programmed to all-ones and the timer interrupt stays quiet.
- dirty set during SCAN/WR_*: the current sequence completes without abort, then rescans from IDLE.
- Reset mid-sequence: mt_wr_en drops asynchronously. The timer resets mtimecmp to 0 alongside, and reprogramming follows from dirty=1.

Optional Feature:
- Macro: MTIMER_SCHED_PERIODIC_EN.
- Defined:
  - reg 3 = 32-bit period (RW, byte-strobed, resets to 0).
  - ctrl bit2 = PERIODIC (RW).
  - On fire with PERIODIC=1: cmp <= cmp + zero-extended period (64-bit wrap), EN stays 1, PEND<=1, dirty<=1.
  - period=0 with PERIODIC behaves as one-shot (EN cleared).
- Undefined: reg 3 and ctrl bit2 read 0, writes ignored, no period registers synthesized.

Test Plan:
- Reset release, mt_gnt tied 1 -> after NUM_CH+1 cycles, three writes: (2,FFFFFFFF), (3,FFFFFFFF), (2,FFFFFFFF). Then mt_wr_en=0, irq=0.
- ch1 cmp=0x0000_0001_0000_0010, EN=1 -> writes (2,FFFFFFFF), (3,00000001), (2,00000010).
  - Drive time_in=0x0000_0001_0000_0010: irq_pending=4'b0010 next cycle, ch1 EN reads 0.
  - Reprogram to all-ones follows.
- ch0 cmp=500, ch2 cmp=300, both EN -> program 300. ch2 fires at time_in=300 -> rescan programs 500.
  - W1C ch2 ctrl=0x2 -> irq_pending=4'b0001 after ch0 fires at 500.
- mt_gnt=0 for 5 cycles in WR_HI -> mt_addr=3 and data held constant all 5 cycles. Exactly 3 grants total.
- Host rewrites ch0 cmp during WR_LO_MAX -> sequence finishes with old value, then a new scan and a new 3-write sequence with the new value.
- With MTIMER_SCHED_PERIODIC_EN: ch3 cmp=100, period=50, PERIODIC|EN.
  - Fire at 100 -> cmp reads 150, EN=1, PEND=1. Next program = 150.
  - Without the macro, reg 3 reads 0 after writing 50.
